// File: rtl/ram_dp_fifo_out_stage.sv
// fifo_out_stage: output register stage of the RAM-backed FIFO.
// Holds the valid flag for the head word and presents the head word either
// straight from the RAM read port (the cycle after a read was issued) or from
// a hold register that captured it.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   issue  - a RAM read is being issued this cycle
//   pop    - consumer takes the current head word this cycle
//   rdata  - RAM read data, valid the cycle after issue
//   valid  - head word present
//   data   - head word
module fifo_out_stage #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  logic                 pop,
    input  logic [DataWidth-1:0] rdata,
    output logic                 valid,
    output logic [DataWidth-1:0] data
);

    logic                 issue_p1;
    logic                 vld_p1;
    logic [DataWidth-1:0] hold_p1;

    // p0 -> p1: track the read in flight, the head-valid flag and the hold copy
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            hold_p1  <= '0;
        end else begin
            issue_p1 <= issue;
            // A fresh issue always refills the head; otherwise a pop empties it.
            if (issue) begin
                vld_p1 <= 1'b1;
            end else if (pop) begin
                vld_p1 <= 1'b0;
            end
            if (issue_p1) begin
                hold_p1 <= rdata;
            end
        end
    end

    // RAM data arrives one cycle after the issue; forward it directly that
    // cycle so there is no extra latency, and replay the hold copy afterwards.
    assign valid = vld_p1;
    assign data  = issue_p1 ? rdata : hold_p1;

endmodule

// File: rtl/ram_dp_fifo.sv
// ram_dp_fifo: single-clock FIFO built around an external simple dual-port
// RAM with 1-cycle read latency, plus one output register stage. Capacity is
// DEPTH words in RAM plus one word in the output stage.
//
// Ports:
//   clk_i, rst_i               - clock and synchronous active-high reset
//   wr_valid_i/wr_ready_o      - write handshake, wr_data_i is the word
//   rd_valid_o/rd_ready_i      - read handshake, rd_data_o is the head word
//   count_o                    - words held (RAM + output stage)
//   ram_wr_en_o/ram_addr_w_o/ram_wdata_o - RAM write port
//   ram_rd_en_o/ram_addr_r_o/ram_rdata_i - RAM read port (1-cycle latency)
module ram_dp_fifo #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [AddrWidth:0]   count_o,
    output logic                 ram_rd_en_o,
    output logic                 ram_wr_en_o,
    output logic [AddrWidth-1:0] ram_addr_r_o,
    output logic [AddrWidth-1:0] ram_addr_w_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    input  logic [DataWidth-1:0] ram_rdata_i
);

    localparam int                 Depth    = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] DepthCnt = (AddrWidth + 1)'(Depth);

    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   mem_cnt;
    logic                 push;
    logic                 pop;
    logic                 issue;

    // mem_cnt counts only words committed to RAM on an earlier edge, so an
    // issue can never target the slot being written this cycle.
    assign wr_ready_o = !rst_i && (mem_cnt < DepthCnt);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;
    assign issue      = !rst_i && (mem_cnt != '0) && (!rd_valid_o || pop);

    assign ram_wr_en_o  = push;
    assign ram_addr_w_o = wr_ptr;
    assign ram_wdata_o  = wr_data_i;
    assign ram_rd_en_o  = issue;
    assign ram_addr_r_o = rd_ptr;

    // p0: pointer and RAM occupancy bookkeeping (pointers wrap at Depth)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    fifo_out_stage #(
        .DataWidth(DataWidth)
    ) u_out_stage (
        .clk  (clk_i),
        .rst  (rst_i),
        .issue(issue),
        .pop  (pop),
        .rdata(ram_rdata_i),
        .valid(rd_valid_o),
        .data (rd_data_o)
    );

    assign count_o = mem_cnt + {{AddrWidth{1'b0}}, rd_valid_o};

endmodule

// File: doc/ram_dp_fifo.md
RAM_DP_FIFO -- requirements
Module: ram_dp_fifo

Interface
REQ-001: Parameter AddrWidth, default 4; log2 of RAM depth. DEPTH = 2^AddrWidth.
REQ-002: Parameter DataWidth, default 32; word width.
REQ-003: clk_i  input  1  single clock; all logic updates on its rising edge.
REQ-004: rst_i  input  1  reset; synchronous, active-high.
REQ-005: wr_valid_i  input  1  producer offers wr_data_i.
REQ-006: wr_ready_o  output  1  FIFO accepts a word this cycle.
REQ-007: wr_data_i  input  DataWidth  write word.
REQ-008: rd_valid_o  output  1  rd_data_o holds the head word.
REQ-009: rd_ready_i  input  1  consumer takes the head word.
REQ-010: rd_data_o  output  DataWidth  head word.
REQ-011: count_o  output  AddrWidth+1  words held (RAM plus output stage), 0..DEPTH+1.
REQ-012: ram_rd_en_o, ram_wr_en_o  output  1 each  active-high RAM enables.
REQ-013: ram_addr_r_o, ram_addr_w_o  output  AddrWidth each  RAM read/write addresses.
REQ-014: ram_wdata_o  output  DataWidth  RAM write data; ram_rdata_i  input  DataWidth  RAM read data with 1-cycle latency.

Function
REQ-015: Push = wr_valid_i & wr_ready_o; pop = rd_valid_o & rd_ready_i.
REQ-016: Push drives ram_wr_en_o=1, ram_addr_w_o=wr_ptr, ram_wdata_o=wr_data_i in the same cycle; wr_ptr increments by 1 and wraps from DEPTH-1 to 0.
REQ-017: wr_ready_o = (mem_cnt < DEPTH); it does not depend on rd_ready_i in the same cycle.
REQ-018: Read issue = (mem_cnt > 0) & (!rd_valid_o | pop); it drives ram_rd_en_o=1, ram_addr_r_o=rd_ptr; rd_ptr increments with wrap.
REQ-019: mem_cnt changes by +1 on push only, -1 on issue only, and is unchanged on simultaneous push and issue.
REQ-020: rd_valid_o is set the cycle after an issue; it is cleared after a pop with no issue; otherwise it holds.
REQ-021: In the cycle after an issue, rd_data_o = ram_rdata_i, which is also captured into a hold register. In all other cycles, rd_data_o = hold register.
REQ-022: Write-to-read latency into an empty FIFO is 2 cycles: push at cycle t gives rd_valid_o=1 at t+2.
REQ-023: Sustained throughput is 1 push and 1 pop per cycle with no bubbles once rd_valid_o=1.
REQ-024: The read and write addresses never collide on a live word, because an issue reads only entries committed on an earlier edge. No bypass path exists.
REQ-025: Pop while rd_valid_o=0 and push while wr_ready_o=0 have no effect.
REQ-026: count_o = mem_cnt + rd_valid_o.

Reset
REQ-027: On rst_i=1 at a clock edge: wr_ptr, rd_ptr, mem_cnt, rd_valid_o, count_o clear to 0, and the hold register clears to 0.
REQ-028: While rst_i=1, ram_rd_en_o, ram_wr_en_o and wr_ready_o are 0. Reset mid-transfer discards all words, including any issue in flight.
REQ-029: RAM contents are not cleared.

Structure
REQ-030: No shared package. DEPTH is a local constant derived from AddrWidth.
REQ-031: The RAM is external. The output stage (valid flag, hold register, mux) is one natural sub-module: fifo_out_stage.
REQ-032: The block is connected to the dual-port RAM wrapper with Pipelined=0, rd/wr enables mapped directly.

Verification (AddrWidth=2, DEPTH=4, capacity 5)
REQ-033: Push 0xA1 into an empty FIFO at cycle 0 -> rd_valid_o=1 with rd_data_o=0xA1 at cycle 2; count_o=1.
REQ-034: Push 0x01..0x06 back-to-back with rd_ready_i=0 -> 5 accepted, wr_ready_o=0 after the fifth, count_o=5; draining yields 0x01..0x05 in order.
REQ-035: Continuous push and pop for 20 words -> 0 bubbles after the first output, pointer wrap at 3->0 handled, data in order.
REQ-036: With count_o=5, push and pop in the same cycle -> push refused, pop accepted, count_o=4 next cycle, then wr_ready_o=1.
REQ-037: Assert rst_i with count_o=3 and a read in flight -> the next cycle has count_o=0 and rd_valid_o=0; a subsequent push of 0x55 appears after 2 cycles.
REQ-038: Randomized rd_ready_i stalls against a scoreboard -> no loss, duplication or reordering, and rd_data_o stays stable while stalled.
